// File: rtl/fu_mult_iter.sv
// fu_mult_iter -- iterative RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU).
//
// Operands are converted to magnitudes on accept, multiplied by shift-and-add
// retiring BITS_PER_CYC multiplier bits per RUN cycle into a 2*XLEN accumulator,
// and the product is negated on the final iteration when the result sign is
// negative. One op in flight; DONE can hand off directly to a new accept.
//
// Optional build macro: MULT_ZERO_BYPASS_EN -- a zero operand skips RUN and the
// op completes with result 0 one cycle after accept.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               discard in-flight op, return to IDLE
//   hold                freeze RUN progress
//   in_valid/in_ready   request handshake; in_op, in_a, in_b, in_tag payload
//   out_valid/out_ready result handshake; out_data, out_tag payload
//   busy                high while in RUN or DONE
module fu_mult_iter #(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 2,
  parameter int TAG_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int ITER  = XLEN / BITS_PER_CYC;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] a_sh;   // multiplicand magnitude, pre-shifted to the current bit weight
  logic [XLEN-1:0]   b_sh;   // multiplier magnitude, low bits are the next chunk
  logic [CNT_W-1:0]  cnt;
  logic              neg;

  logic              a_sgn, b_sgn, accept, last, zero_op;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] partial, acc_nx;

  // MULHU: both unsigned; MULHSU: only a signed; MUL/MULH: both signed.
  assign a_sgn  = (in_op != 2'd3) && in_a[XLEN-1];
  assign b_sgn  = !in_op[1] && in_b[XLEN-1];
  assign a_mag  = a_sgn ? -in_a : in_a;
  assign b_mag  = b_sgn ? -in_b : in_b;

  assign partial = a_sh * {{(2*XLEN-BITS_PER_CYC){1'b0}}, b_sh[BITS_PER_CYC-1:0]};
  assign acc_nx  = acc + partial;
  assign last    = (cnt == CNT_W'(ITER-1));

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (in_a == '0) || (in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // rst_n gates the handshake outputs because reset only takes effect at the edge.
  assign in_ready  = rst_n && !flush &&
                     (state == S_IDLE || (state == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = rst_n && !flush && (state == S_DONE);
  assign busy      = rst_n && (state == S_RUN || state == S_DONE);
  assign out_data  = !out_valid ? '0 :
                     (op_q == 2'd0) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
  assign out_tag   = out_valid ? tag_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
      tag_q <= '0;
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else if (accept) begin
      state <= zero_op ? S_DONE : S_RUN;
      op_q  <= in_op;
      tag_q <= in_tag;
      acc   <= '0;
      a_sh  <= {{XLEN{1'b0}}, a_mag};
      b_sh  <= b_mag;
      cnt   <= '0;
      neg   <= a_sgn ^ b_sgn;
    end else begin
      case (state)
        S_RUN: if (!hold) begin
          a_sh <= a_sh << BITS_PER_CYC;
          b_sh <= b_sh >> BITS_PER_CYC;
          cnt  <= cnt + 1'b1;
          if (last) begin
            acc   <= neg ? -acc_nx : acc_nx;
            state <= S_DONE;
          end else begin
            acc <= acc_nx;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fu_mult_iter.sv
module tb_fu_mult_iter;
  localparam int XLEN = 32;
  localparam int BPC  = 2;
  localparam int TAGW = 5;
  localparam int ITER = XLEN / BPC;

  logic            clk = 0;
  logic            rst_n, flush, hold, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_a, in_b, out_data;
  logic [TAGW-1:0] in_tag, out_tag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fu_mult_iter #(.XLEN(XLEN), .BITS_PER_CYC(BPC), .TAG_W(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a, b;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0, 2'd1: p = sa * sb;
      2'd2:       p = sa * ub;
      default:    p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef MULT_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 1;
`endif
    return ITER + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAGW-1:0] tag);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1;
  endtask

  // Holds in_valid until accepted; returns the number of cycles waited.
  task automatic accept_wait(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        step();
        in_valid = 0;
        return;
      end
      step();
      waited++;
      if (waited > 60) begin
        in_valid = 0;
        chk("accept_timeout", 64'(waited), 64'(0));
        return;
      end
    end
  endtask

  // Counts cycles from `start` until out_valid is seen; leaves us in that cycle.
  task automatic wait_out(input int start, output int lat);
    lat = start;
    forever begin
      @(negedge clk);
      if (out_valid) return;
      step();
      lat++;
      if (lat > 200) begin
        chk("out_valid_timeout", 64'(lat), 64'(0));
        return;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag,
                        input logic [XLEN-1:0] exp);
    int w, lat;
    drive(op, a, b, tag);
    accept_wait(w);
    wait_out(1, lat);
    chk({name, "_data"}, 64'(out_data), 64'(exp));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat(a, b)));
    step();
  endtask

  initial begin
    int w, lat, bad;
    logic [XLEN-1:0] d0;
    logic [TAGW-1:0] t0;

    vecs[0] = '{op: 2'd0, a: 32'd7,         b: 32'hFFFFFFFD, tag: 5'd3,  exp: 32'hFFFFFFEB};
    vecs[1] = '{op: 2'd1, a: 32'h80000000,  b: 32'h80000000, tag: 5'd4,  exp: 32'h40000000};
    vecs[2] = '{op: 2'd3, a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF, tag: 5'd5,  exp: 32'hFFFFFFFE};
    vecs[3] = '{op: 2'd2, a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF, tag: 5'd6,  exp: 32'hFFFFFFFF};
    vecs[4] = '{op: 2'd0, a: 32'd5,         b: 32'd6,        tag: 5'd31, exp: 32'd30};
    vecs[5] = '{op: 2'd0, a: 32'd0,         b: 32'h1234,     tag: 5'd9,  exp: 32'd0};

    rst_n = 0; flush = 0; hold = 0; in_valid = 0; out_ready = 1;
    in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    step();
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_data", 64'(out_data), 64'(0));
    chk("post_rst_out_tag", 64'(out_tag), 64'(0));
    step();

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);

    // Randomized ops with a bias toward corner operands.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [XLEN-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = 0;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom), ref_mul(op, a, b));
    end

    // Backpressure, then back-to-back accept in the same cycle out_ready rises.
    out_ready = 0;
    drive(2'd0, 32'd7, 32'hFFFFFFFD, 5'd3);
    accept_wait(w);
    wait_out(1, lat);
    chk("bp_lat", 64'(lat), 64'(ITER + 1));
    d0 = out_data; t0 = out_tag;
    chk("bp_data", 64'(d0), 64'(32'hFFFFFFEB));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      if (!out_valid || out_data !== d0 || out_tag !== t0 || in_ready) bad++;
    end
    chk("bp_stable", 64'(bad), 64'(0));
    step();
    out_ready = 1;
    drive(2'd3, 32'h12345678, 32'h9ABCDEF0, 5'd17);
    accept_wait(w);
    chk("b2b_accept_wait", 64'(w), 64'(0));
    wait_out(1, lat);
    chk("b2b_lat", 64'(lat), 64'(ITER + 1));
    chk("b2b_data", 64'(out_data), 64'(ref_mul(2'd3, 32'h12345678, 32'h9ABCDEF0)));
    chk("b2b_tag", 64'(out_tag), 64'(17));
    step();

    // Flush in RUN cycle 8.
    drive(2'd0, 32'd123, 32'd456, 5'd2);
    accept_wait(w);
    for (int i = 0; i < 7; i++) step();
    flush = 1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    step();
    flush = 0;
    @(negedge clk);
    chk("post_flush_in_ready", 64'(in_ready), 64'(1));
    chk("post_flush_busy", 64'(busy), 64'(0));
    step();
    run_op("post_flush", 2'd0, 32'd5, 32'd6, 5'd8, 32'd30);

    // Hold for 3 RUN cycles (cycles 3..5).
    drive(2'd1, 32'hDEADBEEF, 32'h01234567, 5'd12);
    accept_wait(w);
    step(); step();
    hold = 1;
    step(); step(); step();
    hold = 0;
    wait_out(6, lat);
    chk("hold_lat", 64'(lat), 64'(ITER + 4));
    chk("hold_data", 64'(out_data), 64'(ref_mul(2'd1, 32'hDEADBEEF, 32'h01234567)));
    step();

    // Reset pulse mid-RUN.
    drive(2'd0, 32'd99, 32'd77, 5'd21);
    accept_wait(w);
    for (int i = 0; i < 4; i++) step();
    rst_n = 0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    step();
    rst_n = 1;
    @(negedge clk);
    chk("after_rst_in_ready", 64'(in_ready), 64'(1));
    chk("after_rst_busy", 64'(busy), 64'(0));
    bad = 0;
    for (int i = 0; i < ITER + 4; i++) begin
      step();
      @(negedge clk);
      if (out_valid || busy) bad++;
    end
    chk("after_rst_quiet", 64'(bad), 64'(0));
    step();
    run_op("after_rst_op", 2'd2, 32'hFFFFFFF0, 32'd3, 5'd1, ref_mul(2'd2, 32'hFFFFFFF0, 32'd3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
